// File: rtl/optical_pkg.sv
// optical_pkg: shared receiver state encoding, default thresholds and majority vote
package optical_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_DARK = 3'd4
  } rx_state_t;
  localparam int unsigned OPT_OVERSAMPLE = 8;
  localparam int unsigned OPT_THRESH_HI = 160;
  localparam int unsigned OPT_THRESH_LO = 96;
  function automatic logic maj3(input logic [2:0] h);
    return (h[0] & h[1]) | (h[0] & h[2]) | (h[1] & h[2]);
  endfunction
endpackage

// File: rtl/optical_threshold_detector.sv
// optical_threshold_detector: hysteresis slicer with 3-deep history and rising-edge flag
module optical_threshold_detector import optical_pkg::*; #(
  parameter int unsigned INTENSITY_W = 8,
  parameter int unsigned THRESH_HI = OPT_THRESH_HI,
  parameter int unsigned THRESH_LO = OPT_THRESH_LO
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INTENSITY_W-1:0] light_level,
  output logic                   light_bit,
  output logic [2:0]             hist,
  output logic                   rise
);
  localparam logic [INTENSITY_W-1:0] HI = INTENSITY_W'(THRESH_HI);
  localparam logic [INTENSITY_W-1:0] LO = INTENSITY_W'(THRESH_LO);
  // levels strictly between LO and HI keep the previous decision
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      light_bit <= 1'b0;
      hist <= '0;
    end else begin
      light_bit <= (light_level >= HI) ? 1'b1 : (light_level <= LO) ? 1'b0 : light_bit;
      hist <= {hist[1:0], light_bit};
    end
  assign rise = light_bit & ~hist[0];
endmodule

// File: rtl/optical_ook_receiver.sv
// optical_ook_receiver: oversampled OOK frame recovery (start=light, LSB-first data, stop=dark)
// with a one-entry valid/ready holding register.
module optical_ook_receiver import optical_pkg::*; #(
  parameter int unsigned INTENSITY_W = 8,
  parameter int unsigned THRESH_HI = OPT_THRESH_HI,
  parameter int unsigned THRESH_LO = OPT_THRESH_LO,
  parameter int unsigned OVERSAMPLE = OPT_OVERSAMPLE,
  parameter int unsigned DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INTENSITY_W-1:0] light_level,
  output logic [DATA_W-1:0]      data,
  output logic                   data_valid,
  input  logic                   data_ready,
  output logic                   light_bit,
  output logic                   frame_err,
  output logic                   overrun
);
  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] MID = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  rx_state_t state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bitidx;
  logic [DATA_W-1:0] shreg;
  logic [2:0] hist;
  logic rise, maj, stop_eval, load;
  optical_threshold_detector #(
    .INTENSITY_W(INTENSITY_W),
    .THRESH_HI(THRESH_HI),
    .THRESH_LO(THRESH_LO)
  ) u_det (
    .clk(clk),
    .rst_n(rst_n),
    .light_level(light_level),
    .light_bit(light_bit),
    .hist(hist),
    .rise(rise)
  );
  always_comb begin
    maj = maj3(hist);
    stop_eval = (state == STOP) && (cnt == LAST);
    load = stop_eval && !maj && (!data_valid || data_ready);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bitidx <= '0;
      shreg <= '0;
    end else begin
      case (state)
        IDLE: if (rise) begin
          state <= START;
          cnt <= '0;
        end
        START: if (cnt == MID) begin
          state <= maj ? DATA : IDLE;
          cnt <= '0;
          bitidx <= '0;
        end else cnt <= cnt + 1'b1;
        DATA: if (cnt == LAST) begin
          shreg <= {maj, shreg[DATA_W-1:1]};
          cnt <= '0;
          bitidx <= (bitidx == LAST_BIT) ? '0 : bitidx + 1'b1;
          if (bitidx == LAST_BIT) state <= STOP;
        end else cnt <= cnt + 1'b1;
        STOP: if (cnt == LAST) begin
          state <= maj ? WAIT_DARK : IDLE;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
        WAIT_DARK: if (!light_bit) begin
          state <= IDLE;
          cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  // a load wins over a same-cycle consume so the new word stays valid
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data <= '0;
      data_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      data <= load ? shreg : data;
      data_valid <= load || (data_valid && !data_ready);
      frame_err <= stop_eval && maj;
      overrun <= stop_eval && !maj && data_valid && !data_ready;
    end
endmodule

// File: tb/tb_optical_ook_receiver.sv
// tb_optical_ook_receiver: directed frames with a word scoreboard and pulse counters.
module tb_optical_ook_receiver;
  import optical_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] light_level = 8'd20;
  logic [7:0] data;
  logic data_valid, data_ready, light_bit, frame_err, overrun;
  int total = 0;
  int bad = 0;
  int ef_cnt = 0;
  int ov_cnt = 0;
  int dv_cycles = 0;
  logic [7:0] exp_q[$];
  optical_ook_receiver dut (
    .clk(clk),
    .rst_n(rst_n),
    .light_level(light_level),
    .data(data),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .light_bit(light_bit),
    .frame_err(frame_err),
    .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [7:0] lvl, input int n);
    light_level = lvl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send_frame(input logic [7:0] w, input bit stop_light);
    drive(8'd200, 8);
    for (int i = 0; i < 8; i++) drive(w[i] ? 8'd200 : 8'd20, 8);
    drive(stop_light ? 8'd200 : 8'd20, 8);
  endtask
  always @(negedge clk)
    if (rst_n) begin
      if (frame_err) ef_cnt++;
      if (overrun) ov_cnt++;
      if (data_valid) dv_cycles++;
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", {24'd0, data}, 32'hFFFF_FFFF);
        else chk("word", {24'd0, data}, {24'd0, exp_q.pop_front()});
      end
    end
  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    int d0, e0, o0;
    data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_light_bit", {31'd0, light_bit}, 0);
    chk("rst_data", {24'd0, data}, 0);
    chk("rst_valid", {31'd0, data_valid}, 0);
    chk("rst_frame_err", {31'd0, frame_err}, 0);
    chk("rst_overrun", {31'd0, overrun}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(8'd20, 10);
    d0 = dv_cycles;
    e0 = ef_cnt;
    o0 = ov_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 0);
    drive(8'd20, 10);
    chk("a5_valid_cycles", dv_cycles - d0, 1);
    chk("a5_frame_err", ef_cnt - e0, 0);
    chk("a5_overrun", ov_cnt - o0, 0);
    for (int i = 0; i < 8; i++) begin
      light_level = i[0] ? 8'd110 : 8'd150;
      @(negedge clk);
      chk("hyst_hold", {31'd0, light_bit}, 0);
      @(posedge clk);
      #1;
    end
    light_level = 8'd170;
    @(negedge clk);
    chk("step_before", {31'd0, light_bit}, 0);
    @(posedge clk);
    #1;
    light_level = 8'd20;
    @(negedge clk);
    chk("step_after", {31'd0, light_bit}, 1);
    drive(8'd20, 20);
    d0 = dv_cycles;
    drive(8'd200, 2);
    drive(8'd20, 20);
    chk("glitch_state", 32'(dut.state), 32'(IDLE));
    chk("glitch_no_valid", dv_cycles - d0, 0);
    e0 = ef_cnt;
    send_frame(8'h3C, 1);
    drive(8'd20, 8);
    chk("3c_frame_err", ef_cnt - e0, 1);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 0);
    drive(8'd20, 10);
    chk("81_consumed", exp_q.size(), 0);
    data_ready = 1'b0;
    o0 = ov_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 0);
    drive(8'd20, 8);
    send_frame(8'h22, 0);
    drive(8'd20, 10);
    chk("ovr_valid", {31'd0, data_valid}, 1);
    chk("ovr_data", {24'd0, data}, 32'h11);
    chk("ovr_pulse", ov_cnt - o0, 1);
    data_ready = 1'b1;
    drive(8'd20, 3);
    chk("ovr_drained", {31'd0, data_valid}, 0);
    chk("ovr_q_empty", exp_q.size(), 0);
    drive(8'd200, 44);
    rst_n = 1'b0;
    #2;
    chk("arst_light_bit", {31'd0, light_bit}, 0);
    chk("arst_data", {24'd0, data}, 0);
    chk("arst_valid", {31'd0, data_valid}, 0);
    light_level = 8'd20;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(8'd20, 10);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 0);
    drive(8'd20, 20);
    chk("final_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/optical_ook_receiver.md
Name: optical_ook_receiver

Overview:
Receive end of the on-off-keyed optical channel driven by the team's optical combiner gates; a photodetector ADC feeds this block with intensity samples. It slices light/dark with hysteresis, oversamples, and recovers framed words: start = light, DATA_W bits LSB-first, stop = dark, idle = dark. Recovered words are presented on a valid/ready interface with a one-entry holding register.

Parameters:
INTENSITY_W, 8, width of photodetector intensity sample
THRESH_HI, 160, level at or above which light_bit becomes 1
THRESH_LO, 96, level at or below which light_bit becomes 0 (THRESH_LO < THRESH_HI)
OVERSAMPLE, 8, clk cycles per optical bit (must be >= 4)
DATA_W, 8, data bits per frame

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous, active-low reset
light_level  in  INTENSITY_W  photodetector intensity sample, synchronous to clk
data  out  DATA_W  recovered word, stable while data_valid=1
data_valid  out  1  recovered word available
data_ready  in  1  consumer accepts word when data_valid & data_ready
light_bit  out  1  registered sliced optical level (debug/monitor)
frame_err  out  1  one-cycle pulse: stop bit sampled as light
overrun  out  1  one-cycle pulse: completed word dropped, holding register full

Behaviour:
- Reset (async assert, sync release): light_bit=0, data=0, data_valid=0, frame_err=0, overrun=0, FSM=IDLE, counters/history=0. Reset mid-frame discards the partial word.
- Slicer: light_bit <= 1 when light_level >= THRESH_HI; <= 0 when light_level <= THRESH_LO; otherwise holds. Unsigned compare.
- History: 3-bit shift register of light_bit; majority(h) = at least 2 of 3 ones. Bit sampling always uses majority.
- cnt: counts 0..OVERSAMPLE-1 and is cleared on each state entry. MID = OVERSAMPLE/2.
- IDLE: on light_bit=1 with previous light_bit=0, go to START with cnt=0.
- START: at cnt==MID, if majority=0 (glitch), return to IDLE. Otherwise clear cnt and go to DATA.
- DATA: at cnt==OVERSAMPLE-1, shift majority into bit position bitidx (LSB first) and clear cnt. After DATA_W bits, go to STOP.
- STOP: at cnt==OVERSAMPLE-1, evaluate majority.
  - majority=0 and (data_valid=0 or data_ready=1): load data, set data_valid=1 on the next edge, go to IDLE.
  - majority=0 and data_valid=1 and data_ready=0: overrun=1 for one cycle, drop the word, keep the held data, go to IDLE.
  - majority=1: frame_err=1 for one cycle, drop the word, go to WAIT_DARK.
- WAIT_DARK: stay until light_bit=0, then go to IDLE. This prevents a stuck-light channel from retriggering.
- Handshake: data_valid stays 1 until a cycle with data_ready=1. A load and a consume in the same cycle leave data_valid=1 with the new word. data_ready while data_valid=0 is ignored.
- Latency: 1 cycle from light_level to light_bit. data_valid rises on the edge after the STOP evaluation cycle.

Decomposition:
- Package optical_pkg:
  - rx_state_t enum: IDLE, START, DATA, STOP, WAIT_DARK.
  - Default constants: OPT_OVERSAMPLE, OPT_THRESH_HI, OPT_THRESH_LO.
  - Function maj3.
- Sub-module optical_threshold_detector: hysteresis slicer, light_bit register, 3-deep history, rising-edge flag.
- FSM, deserialiser and output register stay in optical_ook_receiver.

Test Plan:
Defaults; light=200, dark=20; 80 clk cycles per frame.
1. Reset, then frame 0xA5 with data_ready=1 -> data=0xA5, data_valid high for exactly 1 cycle; frame_err=0, overrun=0.
2. Level toggles 150 <-> 110 after a dark period -> light_bit stays 0; no frame starts. Step to 170 -> light_bit=1 after 1 cycle.
3. 2-cycle light glitch during idle -> START rejects it; FSM returns to IDLE; no data_valid.
4. Frame 0x3C with the stop bit held light -> frame_err pulses once; no data_valid. Dark for 1 bit, then frame 0x81 -> data=0x81.
5. data_ready=0; send 0x11 then 0x22 -> data_valid=1 with data=0x11 held; overrun pulses once at the 0x22 stop. Raise data_ready -> 0x11 is consumed and data_valid falls.
6. rst_n asserted at DATA bit 4 of 0xFF -> outputs clear immediately. Release, then frame 0x5A -> data=0x5A, with no residue from the aborted frame.
